// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, condition-code bit positions, controller states and opcode legality
package alu_pkg;
  localparam logic [3:0] OP_LOADI = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_OR    = 4'b0110;
  localparam logic [3:0] OP_XOR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1000;
  localparam logic [3:0] OP_SHL   = 4'b1001;
  localparam logic [3:0] OP_SHR   = 4'b1011;
  localparam logic [3:0] OP_SRA   = 4'b1100;
  localparam logic [3:0] OP_ROL   = 4'b1101;
  localparam logic [3:0] OP_ROR   = 4'b1110;
  localparam logic [3:0] OP_MUL   = 4'b1111;
  localparam int CC_N = 3;
  localparam int CC_Z = 2;
  localparam int CC_C = 1;
  localparam int CC_V = 0;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  // true for opcodes the ALU executes; LOADI is handled by the controller itself
  function automatic logic op_legal(input logic [3:0] op);
    return !(op inside {OP_LOADI, 4'b0011, 4'b0100, 4'b1010});
  endfunction
endpackage

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: instruction, ALU and response channels of the issue controller
interface alu_issue_ctrl_if #(parameter int WIDTH = 16, parameter int NREG = 8);
  localparam int AW = $clog2(NREG);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [AW-1:0]    in_rd;
  logic [AW-1:0]    in_ra;
  logic [AW-1:0]    in_rb;
  logic [WIDTH-1:0] in_imm;
  logic [WIDTH-1:0] alu_valA;
  logic [WIDTH-1:0] alu_valB;
  logic [3:0]       alu_op;
  logic             alu_sub;
  logic [WIDTH-1:0] alu_result;
  logic [3:0]       alu_cc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [3:0]       out_cc;
  logic             out_err;
  modport slave (
    input  in_valid, in_op, in_rd, in_ra, in_rb, in_imm,
    output in_ready,
    output alu_valA, alu_valB, alu_op, alu_sub,
    input  alu_result, alu_cc,
    output out_valid, out_data, out_cc, out_err,
    input  out_ready
  );
  modport master (
    output in_valid, in_op, in_rd, in_ra, in_rb, in_imm,
    input  in_ready,
    input  alu_valA, alu_valB, alu_op, alu_sub,
    output alu_result, alu_cc,
    input  out_valid, out_data, out_cc, out_err,
    output out_ready
  );
endinterface

// File: rtl/alu_regfile.sv
// alu_regfile: NREG x WIDTH register file, two operand reads plus debug read, one write, R0 fixed at zero
module alu_regfile #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(NREG)-1:0]  ra,
  input  logic [$clog2(NREG)-1:0]  rb,
  input  logic [$clog2(NREG)-1:0]  da,
  output logic [WIDTH-1:0]         rdata_a,
  output logic [WIDTH-1:0]         rdata_b,
  output logic [WIDTH-1:0]         ddata,
  input  logic                     we,
  input  logic [$clog2(NREG)-1:0]  wa,
  input  logic [WIDTH-1:0]         wd
);
  logic [WIDTH-1:0] mem [NREG];
  // storage: async clear, writes to R0 silently dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we && wa != '0) begin
      mem[wa] <= wd;
    end
  end
  assign rdata_a = (ra == '0) ? '0 : mem[ra];
  assign rdata_b = (rb == '0) ? '0 : mem[rb];
  assign ddata   = (da == '0) ? '0 : mem[da];
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: accepts one instruction, drives the ALU, writes back and returns a response
module alu_issue_ctrl import alu_pkg::*; #(
  parameter int WIDTH    = 16,
  parameter int NREG     = 8,
  parameter int MUL_WAIT = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  alu_issue_ctrl_if.slave          bus,
  input  logic [$clog2(NREG)-1:0]  dbg_addr,
  output logic [WIDTH-1:0]         dbg_data
);
  localparam int AW = $clog2(NREG);
  state_t           state, state_nx;
  logic [3:0]       cnt;
  logic [AW-1:0]    rd;
  logic [WIDTH-1:0] imm;
  logic [3:0]       cc_q;
  logic [WIDTH-1:0] rdata_a, rdata_b;
  logic             accept, done, is_loadi, is_legal, we;
  logic [WIDTH-1:0] wd;
  logic [3:0]       loadi_cc;
  assign accept   = state == IDLE && bus.in_valid;
  assign done     = state == ISSUE && cnt == '0;
  assign is_loadi = bus.alu_op == OP_LOADI;
  assign is_legal = op_legal(bus.alu_op);
  assign we       = done && (is_legal || is_loadi);
  assign wd       = is_loadi ? imm : bus.alu_result;
  assign loadi_cc = {imm[WIDTH-1], imm == '0, 2'b00};
  assign bus.in_ready  = state == IDLE;
  assign bus.out_valid = state == RESP;
  alu_regfile #(.WIDTH(WIDTH), .NREG(NREG)) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra      (bus.in_ra),
    .rb      (bus.in_rb),
    .da      (dbg_addr),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b),
    .ddata   (dbg_data),
    .we      (we),
    .wa      (rd),
    .wd      (wd)
  );
  // state register; reset aborts any instruction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // next state: one instruction at a time, response held until taken
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = bus.in_valid ? ISSUE : IDLE;
      ISSUE:   state_nx = (cnt == '0) ? RESP : ISSUE;
      RESP:    state_nx = bus.out_ready ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  // ALU operands are captured on accept and held through ISSUE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.alu_valA <= '0;
      bus.alu_valB <= '0;
      bus.alu_op   <= '0;
      bus.alu_sub  <= 1'b0;
    end else if (accept) begin
      bus.alu_valA <= rdata_a;
      bus.alu_valB <= rdata_b;
      bus.alu_op   <= bus.in_op;
      bus.alu_sub  <= bus.in_op == OP_SUB;
    end
  end
  // destination, immediate and the multicycle wait counter for MUL
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      rd  <= '0;
      imm <= '0;
    end else if (accept) begin
      cnt <= (bus.in_op == OP_MUL) ? 4'(MUL_WAIT - 1) : 4'd0;
      rd  <= bus.in_rd;
      imm <= bus.in_imm;
    end else if (state == ISSUE && cnt != '0) begin
      cnt <= cnt - 4'd1;
    end
  end
  // response capture on the writeback edge; illegal ops report the last ALU flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_data <= '0;
      bus.out_cc   <= '0;
      bus.out_err  <= 1'b0;
      cc_q         <= '0;
    end else if (done) begin
      bus.out_data <= is_loadi ? imm : is_legal ? bus.alu_result : '0;
      bus.out_cc   <= is_loadi ? loadi_cc : is_legal ? bus.alu_cc : cc_q;
      bus.out_err  <= !is_loadi && !is_legal;
      cc_q         <= is_legal ? bus.alu_cc : cc_q;
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: random and directed instructions against a register-array model, bench plays the ALU
module tb_alu_issue_ctrl;
  import alu_pkg::*;
  localparam int MW = 3;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  dbg_addr = '0;
  logic [15:0] dbg_data;
  logic [15:0] rf [8];
  logic [3:0]  cc_m;
  int checks = 0;
  int errors = 0;
  alu_issue_ctrl_if bus();
  alu_issue_ctrl #(.WIDTH(16), .NREG(8), .MUL_WAIT(MW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );
  always #5 clk = ~clk;
  function automatic logic [19:0] alu_f(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] r;
    logic c;
    c = 1'b0;
    case (op)
      4'b0001: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16]; end
      4'b0010: r = a - b;
      4'b0101: r = a & b;
      4'b0110: r = a | b;
      4'b0111: r = a ^ b;
      4'b1000: r = ~a;
      4'b1001: r = a << b[3:0];
      4'b1011: r = a >> b[3:0];
      4'b1100: r = $signed(a) >>> b[3:0];
      4'b1101: r = (a << b[3:0]) | (a >> (16 - b[3:0]));
      4'b1110: r = (a >> b[3:0]) | (a << (16 - b[3:0]));
      4'b1111: r = a * b;
      default: return {4'hF, a ^ ~b};
    endcase
    return {r[15], r == 16'h0, c, 1'b0, r};
  endfunction
  assign {bus.alu_cc, bus.alu_result} = alu_f(bus.alu_op, bus.alu_valA, bus.alu_valB);
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic chk_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      chk(tag, dbg_data, rf[i]);
    end
  endtask
  task automatic run(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb,
                     input logic [15:0] imm, input int hold);
    logic [15:0] a, b, e_data;
    logic [3:0]  e_cc;
    logic        e_err, wr;
    logic [19:0] f;
    int lat, e_lat;
    a = rf[ra];
    b = rf[rb];
    f = alu_f(op, a, b);
    e_lat = (op == 4'b1111) ? MW : 1;
    wr = 1'b1;
    e_err = 1'b0;
    if (op == 4'b0000) begin
      e_data = imm;
      e_cc = {imm[15], imm == 16'h0, 2'b00};
    end else if (op == 4'b0011 || op == 4'b0100 || op == 4'b1010) begin
      e_data = 16'h0;
      e_cc = cc_m;
      e_err = 1'b1;
      wr = 1'b0;
    end else begin
      e_data = f[15:0];
      e_cc = f[19:16];
      cc_m = e_cc;
    end
    @(negedge clk);
    chk("in_ready_idle", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_op = op;
    bus.in_rd = rd;
    bus.in_ra = ra;
    bus.in_rb = rb;
    bus.in_imm = imm;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_op = 4'($urandom);
    bus.in_rd = 3'($urandom);
    bus.in_ra = 3'($urandom);
    bus.in_rb = 3'($urandom);
    bus.in_imm = 16'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      chk("alu_valA", bus.alu_valA, a);
      chk("alu_valB", bus.alu_valB, b);
      chk("alu_op", bus.alu_op, op);
      chk("alu_sub", bus.alu_sub, op == 4'b0010);
      chk("in_ready_busy", bus.in_ready, 0);
      lat++;
      @(negedge clk);
    end
    chk("latency", lat, e_lat);
    chk("out_data", bus.out_data, e_data);
    chk("out_cc", bus.out_cc, e_cc);
    chk("out_err", bus.out_err, e_err);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_in_ready", bus.in_ready, 0);
      chk("hold_data", bus.out_data, e_data);
      chk("hold_cc", bus.out_cc, e_cc);
      chk("hold_err", bus.out_err, e_err);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("valid_drop", bus.out_valid, 0);
    chk("in_ready_back", bus.in_ready, 1);
    if (wr && rd != 3'd0) rf[rd] = e_data;
    chk_regs("regfile");
  endtask
  task automatic mid_reset();
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op = 4'b1111;
    bus.in_rd = 3'd5;
    bus.in_ra = 3'd1;
    bus.in_rb = 3'd2;
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_valA", bus.alu_valA, 0);
    chk("rst_op", bus.alu_op, 0);
    for (int i = 0; i < 8; i++) rf[i] = 16'h0;
    cc_m = 4'h0;
    chk_regs("rst_regs");
    repeat (4) @(negedge clk);
    chk("rst_no_resp", bus.out_valid, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_valid", bus.out_valid, 0);
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_op = '0;
    bus.in_rd = '0;
    bus.in_ra = '0;
    bus.in_rb = '0;
    bus.in_imm = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) rf[i] = 16'h0;
    cc_m = 4'h0;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", bus.in_ready, 1);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_out_data", bus.out_data, 0);
    chk("reset_out_cc", bus.out_cc, 0);
    chk("reset_out_err", bus.out_err, 0);
    chk("reset_valA", bus.alu_valA, 0);
    chk("reset_valB", bus.alu_valB, 0);
    chk("reset_op", bus.alu_op, 0);
    chk("reset_sub", bus.alu_sub, 0);
    chk_regs("reset_regs");
    rst_n = 1'b1;
    run(4'b0000, 3'd1, 3'd0, 3'd0, 16'h0005, 0);
    run(4'b0000, 3'd2, 3'd0, 3'd0, 16'h0003, 0);
    run(4'b0010, 3'd3, 3'd1, 3'd2, 16'h0, 0);
    chk("sub_r3", rf[3], 16'h0002);
    run(4'b0000, 3'd4, 3'd0, 3'd0, 16'hFFFF, 0);
    run(4'b0000, 3'd6, 3'd0, 3'd0, 16'h0001, 0);
    run(4'b0001, 3'd5, 3'd4, 3'd6, 16'h0, 0);
    chk("add_wrap_cc", bus.out_cc, 4'b0110);
    run(4'b1111, 3'd7, 3'd1, 3'd2, 16'h0, 5);
    run(4'b1010, 3'd1, 3'd2, 3'd3, 16'h0, 0);
    run(4'b0011, 3'd2, 3'd4, 3'd1, 16'h0, 1);
    run(4'b0000, 3'd0, 3'd0, 3'd0, 16'h1234, 0);
    run(4'b0001, 3'd0, 3'd1, 3'd2, 16'h0, 0);
    run(4'b0000, 3'd3, 3'd0, 3'd0, 16'h0000, 0);
    run(4'b1001, 3'd2, 3'd1, 3'd2, 16'h0, 0);
    for (int n = 0; n < 250; n++)
      run(4'($urandom_range(0, 15)), 3'($urandom), 3'($urandom), 3'($urandom), 16'($urandom),
          int'($urandom_range(0, 3)));
    mid_reset();
    for (int n = 0; n < 40; n++)
      run(4'($urandom_range(0, 15)), 3'($urandom), 3'($urandom), 3'($urandom), 16'($urandom),
          int'($urandom_range(0, 2)));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
